indirim_hesaplayici_seri: RTL and testbench

- Sequential, parametrised successor of the combinational discount calculator.
- Accepts one pricing request over a valid/ready handshake and builds a list of up to four percentage factors.
- Applies the factors with one multiply per cycle, then produces the TL/kuruş result with shift-subtract dividers.
- Holds the result on a valid/ready output port until it is taken. The price width, cap, surcharge and floor are generics.

---
 rtl/indirim_hesaplayici_seri_if.sv | 29 ++
 rtl/indirim_hesaplayici_seri.sv | 214 +++++++++++++++++++++
 tb/tb_indirim_hesaplayici_seri.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/indirim_hesaplayici_seri_if.sv
// Request/result handshake bundle for the sequential discount calculator.
// The master drives a pricing request and consumes the result; the slave is the calculator.
interface indirim_hesaplayici_seri_if #(
    parameter int FIYAT_W = 13
);
    logic                 giris_gecerli;
    logic                 giris_hazir;
    logic [FIYAT_W-1:0]   urun_fiyati;
    logic [1:0]           pazarlik;
    logic [2:0]           musteri_tipi;
    logic [1:0]           musteri_davranisi;
    logic [3:0]           urun_tipi;
    logic                 cikis_gecerli;
    logic                 cikis_hazir;
    logic [FIYAT_W+6:0]   indirimli_fiyat;
    logic                 tavan_uygulandi;

    modport master (
        output giris_gecerli, urun_fiyati, pazarlik, musteri_tipi,
               musteri_davranisi, urun_tipi, cikis_hazir,
        input  giris_hazir, cikis_gecerli, indirimli_fiyat, tavan_uygulandi
    );

    modport slave (
        input  giris_gecerli, urun_fiyati, pazarlik, musteri_tipi,
               musteri_davranisi, urun_tipi, cikis_hazir,
        output giris_hazir, cikis_gecerli, indirimli_fiyat, tavan_uygulandi
    );
endinterface

// File: rtl/indirim_hesaplayici_seri.sv
// Sequential discount calculator: builds a list of four percentage factors at
// accept time, multiplies them into the price one per cycle, then converts the
// scaled product into TL/kurus with two restoring dividers (by 10^6, then by 100).
// The result is held on a valid/ready port until the consumer takes it.
module indirim_hesaplayici_seri #(
    parameter int FIYAT_W           = 13,
    parameter int TAVAN_TL          = 5000,
    parameter int ENFLASYON_CARPANI = 110,
    parameter int TABAN_CARPANI     = 75
) (
    input  logic                      clk,
    input  logic                      rst_n,
    indirim_hesaplayici_seri_if.slave bus
);
    localparam int ACC_W = FIYAT_W + 28;
    localparam int QW    = FIYAT_W + 7;
    localparam int SAY_W = $clog2(ACC_W + 1);

    localparam logic [ACC_W-1:0] TAVAN_KURUS  = ACC_W'(TAVAN_TL * 100);
    localparam logic [20:0]      BOLEN_MILYON = 21'd1000000;
    localparam logic [20:0]      BOLEN_YUZ    = 21'd100;
    localparam logic [31:0]      TABAN_ESIK   = 32'(TABAN_CARPANI) * 32'd1000000;
    localparam logic [6:0]       F_YUZ        = 7'd100;
    localparam logic [6:0]       F_ENF        = 7'(ENFLASYON_CARPANI);
    localparam logic [6:0]       F_TABAN      = 7'(TABAN_CARPANI);

    typedef enum logic [2:0] {
        BOS,
        CARP,
        BOL1,
        SINIR,
        BOL2,
        SONUC
    } durum_t;

    durum_t                r_durum;
    logic [ACC_W-1:0]      r_acc;
    logic [19:0]           r_kalan;
    logic [3:0][6:0]       r_liste;
    logic [SAY_W-1:0]      r_sayac;
    logic                  r_cikis_gecerli;
    logic [QW-1:0]         r_indirimli_fiyat;
    logic                  r_tavan;

    logic [3:0][6:0]       w_indirimler;
    logic [6:0]            w_en_kucuk;
    logic [31:0]           w_carpim;
    logic [3:0][6:0]       w_liste;
    logic [20:0]           w_bolen;
    logic [20:0]           w_deneme;
    logic                  w_bit;
    logic [19:0]           w_yeni_kalan;
    logic [ACC_W-1:0]      w_yeni_acc;
    logic [ACC_W-1:0]      w_carp_sonuc;

    // Appends the discount factors in fixed order; untouched slots stay at 100 (neutral).
    function automatic logic [3:0][6:0] indirimListesi(
        input logic [1:0] pz,
        input logic [2:0] mt,
        input logic [1:0] md,
        input logic [3:0] ut
    );
        logic [3:0][6:0] l;
        logic [2:0]      n;
        l = {4{F_YUZ}};
        n = 3'd0;
        if (ut != 4'd0 && ut != 4'd2) begin
            case (pz)
                2'd1:    begin l[n[1:0]] = 7'd97; n = n + 3'd1; end
                2'd2:    begin l[n[1:0]] = 7'd92; n = n + 3'd1; end
                2'd3:    begin l[n[1:0]] = 7'd81; n = n + 3'd1; end
                default: ;
            endcase
            case (mt)
                3'd0:    begin l[n[1:0]] = 7'd98; n = n + 3'd1; end
                3'd1:    begin l[n[1:0]] = 7'd90; n = n + 3'd1; end
                3'd2:    begin
                    l[n[1:0]] = 7'd85;
                    n = n + 3'd1;
                    l[n[1:0]] = 7'd90;
                    n = n + 3'd1;
                end
                3'd4:    begin l[n[1:0]] = 7'd99; n = n + 3'd1; end
                default: ;
            endcase
            if (md == 2'd2) begin
                l[n[1:0]] = 7'd95;
            end
        end
        return l;
    endfunction

    // Smallest factor of a list; a list of only neutral slots yields 100.
    function automatic logic [6:0] enKucuk(input logic [3:0][6:0] l);
        logic [6:0] m;
        m = l[0];
        for (int i = 1; i < 4; i++) begin
            if (l[i] < m) begin
                m = l[i];
            end
        end
        return m;
    endfunction

    // Final factor list for the request currently on the input port.
    always_comb begin
        w_indirimler = indirimListesi(bus.pazarlik, bus.musteri_tipi,
                                      bus.musteri_davranisi, bus.urun_tipi);
        w_en_kucuk   = enKucuk(w_indirimler);
        w_carpim     = 32'(w_indirimler[0]) * 32'(w_indirimler[1]) *
                       32'(w_indirimler[2]) * 32'(w_indirimler[3]);
        w_liste      = w_indirimler;
        if (bus.musteri_davranisi == 2'd0) begin
            w_liste = {F_YUZ, F_YUZ, w_en_kucuk, F_ENF};
        end else if ((bus.urun_tipi == 4'd5 || bus.urun_tipi == 4'd8) &&
                     (w_carpim < TABAN_ESIK)) begin
            w_liste = {F_YUZ, F_YUZ, F_YUZ, F_TABAN};
        end
    end

    // Shared shift-subtract step and multiply step; the divisor follows the active divide phase.
    always_comb begin
        w_bolen      = (r_durum == BOL2) ? BOLEN_YUZ : BOLEN_MILYON;
        w_deneme     = {r_kalan, r_acc[ACC_W-1]};
        w_bit        = (w_deneme >= w_bolen);
        w_yeni_kalan = w_bit ? 20'(w_deneme - w_bolen) : w_deneme[19:0];
        w_yeni_acc   = {r_acc[ACC_W-2:0], w_bit};
        w_carp_sonuc = r_acc * {{(ACC_W-7){1'b0}}, r_liste[r_sayac[1:0]]};
    end

    // Main controller and datapath registers: accept, multiply, divide, cap, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum           <= BOS;
            r_acc             <= '0;
            r_kalan           <= '0;
            r_liste           <= {4{F_YUZ}};
            r_sayac           <= '0;
            r_cikis_gecerli   <= 1'b0;
            r_indirimli_fiyat <= '0;
            r_tavan           <= 1'b0;
        end else begin
            case (r_durum)
                BOS: begin
                    if (bus.giris_gecerli) begin
                        r_liste <= w_liste;
                        r_acc   <= ACC_W'(bus.urun_fiyati);
                        r_sayac <= '0;
                        r_durum <= CARP;
                    end
                end
                CARP: begin
                    r_acc <= w_carp_sonuc;
                    if (r_sayac == SAY_W'(3)) begin
                        r_sayac <= '0;
                        r_kalan <= '0;
                        r_durum <= BOL1;
                    end else begin
                        r_sayac <= r_sayac + SAY_W'(1);
                    end
                end
                BOL1: begin
                    r_acc   <= w_yeni_acc;
                    r_kalan <= w_yeni_kalan;
                    if (r_sayac == SAY_W'(ACC_W - 1)) begin
                        r_sayac <= '0;
                        r_durum <= SINIR;
                    end else begin
                        r_sayac <= r_sayac + SAY_W'(1);
                    end
                end
                SINIR: begin
                    if (r_acc >= TAVAN_KURUS) begin
                        r_indirimli_fiyat <= {FIYAT_W'(TAVAN_TL), 7'd0};
                        r_tavan           <= 1'b1;
                        r_cikis_gecerli   <= 1'b1;
                        r_durum           <= SONUC;
                    end else begin
                        // Left-align the kurus total so the same MSB-first step divides it by 100.
                        r_acc   <= {r_acc[QW-1:0], {(ACC_W-QW){1'b0}}};
                        r_kalan <= '0;
                        r_durum <= BOL2;
                    end
                end
                BOL2: begin
                    r_acc   <= w_yeni_acc;
                    r_kalan <= w_yeni_kalan;
                    if (r_sayac == SAY_W'(QW - 1)) begin
                        r_indirimli_fiyat <= {w_yeni_acc[FIYAT_W-1:0], w_yeni_kalan[6:0]};
                        r_tavan           <= 1'b0;
                        r_cikis_gecerli   <= 1'b1;
                        r_sayac           <= '0;
                        r_durum           <= SONUC;
                    end else begin
                        r_sayac <= r_sayac + SAY_W'(1);
                    end
                end
                SONUC: begin
                    if (bus.cikis_hazir) begin
                        r_cikis_gecerli <= 1'b0;
                        r_durum         <= BOS;
                    end
                end
                default: r_durum <= BOS;
            endcase
        end
    end

    assign bus.giris_hazir     = (r_durum == BOS);
    assign bus.cikis_gecerli   = r_cikis_gecerli;
    assign bus.indirimli_fiyat = r_indirimli_fiyat;
    assign bus.tavan_uygulandi = r_tavan;

endmodule

// File: tb/tb_indirim_hesaplayici_seri.sv
// Scoreboard bench for the sequential discount calculator: the driver pushes
// model predictions at accept time, a monitor pops and compares each result.
module tb_indirim_hesaplayici_seri;
    localparam int FIYAT_W  = 13;
    localparam int ACC_W    = FIYAT_W + 28;
    localparam int QW       = FIYAT_W + 7;
    localparam int TAVAN_TL = 5000;
    localparam int ENF      = 110;
    localparam int TABAN    = 75;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    indirim_hesaplayici_seri_if #(.FIYAT_W(FIYAT_W)) bus ();

    indirim_hesaplayici_seri #(
        .FIYAT_W(FIYAT_W),
        .TAVAN_TL(TAVAN_TL),
        .ENFLASYON_CARPANI(ENF),
        .TABAN_CARPANI(TABAN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [FIYAT_W+6:0] fiyat;
        logic               tavan;
        int                 kabulKenari;
        int                 gecikme;
        int                 bekle;
    } expItem_t;

    expItem_t scoreboard[$];
    int errors     = 0;
    int checks     = 0;
    int cycleCount = 0;

    // Counts rising edges so latency can be measured from the accept edge.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    function automatic longint listProduct(input int q[$]);
        longint p;
        p = 1;
        foreach (q[i]) p = p * q[i];
        for (int i = q.size(); i < 4; i++) p = p * 100;
        return p;
    endfunction

    // Reference model straight from the pricing rules, using plain integer arithmetic.
    function automatic expItem_t referenceModel(input int price, input int pz, input int mt,
                                                input int md, input int ut);
        expItem_t r;
        int       discounts[$];
        int       factors[$];
        longint   kurus;
        int       m;
        if (!(ut == 0 || ut == 2)) begin
            if (pz == 1) discounts.push_back(97);
            else if (pz == 2) discounts.push_back(92);
            else if (pz == 3) discounts.push_back(81);
            if (mt == 0) discounts.push_back(98);
            else if (mt == 1) discounts.push_back(90);
            else if (mt == 2) begin
                discounts.push_back(85);
                discounts.push_back(90);
            end else if (mt == 4) discounts.push_back(99);
            if (md == 2) discounts.push_back(95);
        end
        if (md == 0) begin
            m = 100;
            foreach (discounts[i]) if (discounts[i] < m) m = discounts[i];
            factors.push_back(ENF);
            factors.push_back(m);
        end else begin
            factors = discounts;
            if ((ut == 5 || ut == 8) && (listProduct(factors) / 1000000 < TABAN)) begin
                factors.delete();
                factors.push_back(TABAN);
            end
        end
        kurus         = longint'(price) * listProduct(factors) / 1000000;
        r.kabulKenari = 0;
        r.bekle       = 0;
        if (kurus >= longint'(TAVAN_TL) * 100) begin
            r.fiyat   = (FIYAT_W+7)'(longint'(TAVAN_TL) * 128);
            r.tavan   = 1'b1;
            r.gecikme = 5 + ACC_W;
        end else begin
            r.fiyat   = (FIYAT_W+7)'((kurus / 100) * 128 + (kurus % 100));
            r.tavan   = 1'b0;
            r.gecikme = 5 + ACC_W + QW;
        end
        return r;
    endfunction

    // Presents one request, waits (bounded) for the accept, and records the prediction.
    task automatic applyStimulus(input int price, input int pz, input int mt, input int md,
                                 input int ut, input int hold);
        expItem_t e;
        bit       accepted;
        accepted = 1'b0;
        @(negedge clk);
        bus.urun_fiyati       = FIYAT_W'(price);
        bus.pazarlik          = 2'(pz);
        bus.musteri_tipi      = 3'(mt);
        bus.musteri_davranisi = 2'(md);
        bus.urun_tipi         = 4'(ut);
        bus.giris_gecerli     = 1'b1;
        for (int t = 0; t < 400 && !accepted; t++) begin
            if (t > 0) @(negedge clk);
            if (bus.giris_hazir === 1'b1) begin
                e             = referenceModel(price, pz, mt, md, ut);
                e.kabulKenari = cycleCount + 1;
                e.bekle       = hold;
                scoreboard.push_back(e);
                accepted      = 1'b1;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: actual=0 required=1");
        end
        @(negedge clk);
        bus.giris_gecerli = 1'b0;
    endtask

    // Monitor: compares each presented result, holds it for the requested time, then takes it.
    initial begin : monitor
        expItem_t e;
        bit       haveExp;
        bus.cikis_hazir = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.cikis_gecerli === 1'b1) begin
                haveExp = (scoreboard.size() != 0);
                if (!haveExp) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResult: actual=%0d required=none", bus.indirimli_fiyat);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("indirimliFiyat", 64'(bus.indirimli_fiyat), 64'(e.fiyat));
                    checkOutput("tavanUygulandi", 64'(bus.tavan_uygulandi), 64'(e.tavan));
                    checkOutput("latency", 64'(cycleCount - e.kabulKenari), 64'(e.gecikme));
                    for (int k = 0; k < e.bekle; k++) begin
                        @(negedge clk);
                        checkOutput("holdValid", 64'(bus.cikis_gecerli), 64'd1);
                        checkOutput("holdFiyat", 64'(bus.indirimli_fiyat), 64'(e.fiyat));
                        checkOutput("holdTavan", 64'(bus.tavan_uygulandi), 64'(e.tavan));
                        checkOutput("holdGirisHazir", 64'(bus.giris_hazir), 64'd0);
                    end
                end
                bus.cikis_hazir = 1'b1;
                @(negedge clk);
                bus.cikis_hazir = 1'b0;
                checkOutput("validDropped", 64'(bus.cikis_gecerli), 64'd0);
                checkOutput("idleAfterTake", 64'(bus.giris_hazir), 64'd1);
                if (haveExp) begin
                    checkOutput("fiyatKept", 64'(bus.indirimli_fiyat), 64'(e.fiyat));
                    checkOutput("tavanKept", 64'(bus.tavan_uygulandi), 64'(e.tavan));
                end
            end
        end
    end

    // Main sequence: reset, directed cases, random traffic, mid-divide reset, drain.
    initial begin : driver
        bit drained;
        bus.giris_gecerli     = 1'b0;
        bus.urun_fiyati       = '0;
        bus.pazarlik          = '0;
        bus.musteri_tipi      = '0;
        bus.musteri_davranisi = '0;
        bus.urun_tipi         = '0;
        #1;
        checkOutput("resetValid", 64'(bus.cikis_gecerli), 64'd0);
        checkOutput("resetFiyat", 64'(bus.indirimli_fiyat), 64'd0);
        checkOutput("resetTavan", 64'(bus.tavan_uygulandi), 64'd0);
        checkOutput("resetGirisHazir", 64'(bus.giris_hazir), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1000, 0, 3, 1, 1, 0);
        applyStimulus(1000, 0, 0, 0, 0, 1);
        applyStimulus(999, 2, 1, 0, 1, 2);
        applyStimulus(1234, 3, 2, 2, 1, 0);
        applyStimulus(8191, 0, 0, 0, 0, 10);
        applyStimulus(1234, 3, 2, 2, 5, 3);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(int'($urandom_range(0, 8191)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        // Abort a request in the middle of the first divide.
        drained = 1'b0;
        for (int t = 0; t < 400 && !drained; t++) begin
            @(negedge clk);
            drained = (scoreboard.size() == 0) && (bus.giris_hazir === 1'b1);
        end
        repeat (2) @(negedge clk);
        applyStimulus(4321, 1, 0, 2, 3, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortValid", 64'(bus.cikis_gecerli), 64'd0);
        checkOutput("abortFiyat", 64'(bus.indirimli_fiyat), 64'd0);
        checkOutput("abortTavan", 64'(bus.tavan_uygulandi), 64'd0);
        checkOutput("abortGirisHazir", 64'(bus.giris_hazir), 64'd1);
        scoreboard.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1234, 3, 2, 2, 1, 1);
        applyStimulus(2500, 2, 4, 3, 8, 0);

        drained = 1'b0;
        for (int t = 0; t < 1000 && !drained; t++) begin
            @(negedge clk);
            drained = (scoreboard.size() == 0) && (bus.giris_hazir === 1'b1);
        end
        if (!drained) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: actual=%0d pending required=0 pending", scoreboard.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
